arm_mem_responder: RTL and testbench

//   Memory-side responder for the multi-cycle ARM core's unified Adr/WriteData/MemWrite/ReadData bus.

---
 rtl/arm_mem_responder.sv | 139 +++++++++++++
 tb/tb_arm_mem_responder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/arm_mem_responder.sv
// rtl/arm_mem_responder.sv - memory-side responder: word RAM plus LED, TX FIFO and timer I/O
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   MemWrite, Adr,      core bus: write strobe, byte address (word access),
//   WriteData, ReadData write data, combinational read data
//   LED                 LED register
//   TxValid, TxData,    TX FIFO head stream (valid/byte) and sink ready
//   TxReady
//   TimerIrq            sticky timer-match flag
module arm_mem_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  LED,
    output logic        TxValid,
    output logic [7:0]  TxData,
    input  logic        TxReady,
    output logic        TimerIrq
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0] ram_q  [RAM_WORDS];
    logic [7:0]  fifo_q [FIFO_DEPTH];

    logic [7:0]  led_q,    led_d;
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic        ovf_q,    ovf_d;
    logic [31:0] cnt_q,    cnt_d;
    logic [31:0] cmp_q,    cmp_d;
    logic        irq_q,    irq_d;

    logic        is_io;
    logic [7:0]  io_off;
    logic        wr_ram, wr_led, wr_tx, wr_timer, wr_cmp, wr_clr;
    logic        empty, full, pop, push_ok;
    logic [AW-1:0] ram_idx;
    logic        unused_adr;

    assign is_io   = Adr[31];
    assign io_off  = Adr[7:0];
    assign ram_idx = Adr[AW+1:2];
    // Remaining address bits alias by design.
    assign unused_adr = ^{Adr[30:8], Adr[1:0]};

    assign wr_ram   = MemWrite & ~is_io;
    assign wr_led   = MemWrite & is_io & (io_off == 8'h00);
    assign wr_tx    = MemWrite & is_io & (io_off == 8'h04);
    assign wr_timer = MemWrite & is_io & (io_off == 8'h08);
    assign wr_cmp   = MemWrite & is_io & (io_off == 8'h0C);
    assign wr_clr   = MemWrite & is_io & (io_off == 8'h10);

    // Extra wrap bit distinguishes full from empty when the slot indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop     = ~empty & TxReady;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok = wr_tx & (~full | pop);

    always_comb begin
        led_d    = led_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q + 32'd1;
        cmp_d    = cmp_q;
        irq_d    = irq_q;

        if (wr_led)   led_d    = WriteData[7:0];
        if (push_ok)  wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_tx && full && !pop) ovf_d = 1'b1;
        if (wr_clr)   ovf_d    = 1'b0;
        if (wr_timer) cnt_d    = WriteData;
        if (wr_cmp)   cmp_d    = WriteData;
        // Clear from a CMP write wins over a same-cycle match.
        if (wr_cmp)               irq_d = 1'b0;
        else if (cnt_q == cmp_q)  irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            led_q    <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= 32'h0;
            cmp_q    <= 32'hFFFF_FFFF;
            irq_q    <= 1'b0;
        end else begin
            led_q    <= led_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            irq_q    <= irq_d;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_ram) ram_q[ram_idx] <= WriteData;
    end

    // FIFO storage needs no reset: TxData is masked while empty.
    always_ff @(posedge clk) begin
        if (reset && push_ok) fifo_q[wr_ptr_q[PW-1:0]] <= WriteData[7:0];
    end

    always_comb begin
        ReadData = 32'h0;
        if (!is_io) begin
            ReadData = ram_q[ram_idx];
        end else begin
            case (io_off)
                8'h00:   ReadData = {24'h0, led_q};
                8'h04:   ReadData = {28'h0, ovf_q, irq_q, full, empty};
                8'h08:   ReadData = cnt_q;
                8'h0C:   ReadData = cmp_q;
                default: ReadData = 32'h0;
            endcase
        end
    end

    assign LED      = led_q;
    assign TxValid  = ~empty;
    assign TxData   = empty ? 8'h00 : fifo_q[rd_ptr_q[PW-1:0]];
    assign TimerIrq = irq_q;
endmodule

// File: tb/tb_arm_mem_responder.sv
// tb/tb_arm_mem_responder.sv - directed self-checking bench for arm_mem_responder
module tb_arm_mem_responder;
    localparam int RAM_WORDS = 64;
    localparam logic [31:0] A_LED   = 32'h8000_0000;
    localparam logic [31:0] A_TX    = 32'h8000_0004;
    localparam logic [31:0] A_TIMER = 32'h8000_0008;
    localparam logic [31:0] A_CMP   = 32'h8000_000C;
    localparam logic [31:0] A_CLR   = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Adr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic [7:0]  LED;
    logic        TxValid;
    logic [7:0]  TxData;
    logic        TxReady = 1'b0;
    logic        TimerIrq;

    int checks = 0;
    int errors = 0;

    arm_mem_responder #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr),
        .WriteData(WriteData), .ReadData(ReadData), .LED(LED),
        .TxValid(TxValid), .TxData(TxData), .TxReady(TxReady),
        .TimerIrq(TimerIrq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Single-cycle write; returns at the negedge after the write edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Adr = a; WriteData = d; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Adr = a;
        #1;
        check(tag, ReadData, exp);
    endtask

    initial begin
        // 1: reset state
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_led", {24'h0, LED}, 32'h0);
        check("rst_txvalid", {31'h0, TxValid}, 32'h0);
        check("rst_irq", {31'h0, TimerIrq}, 32'h0);
        rd("rst_status", A_TX, 32'h1);

        // 2: RAM write, alias, survives reset
        wr(32'h10, 32'hDEAD_BEEF);
        rd("ram_rd", 32'h10, 32'hDEAD_BEEF);
        rd("ram_alias", 32'h10 + 4 * RAM_WORDS, 32'hDEAD_BEEF);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        rd("ram_after_rst", 32'h10, 32'hDEAD_BEEF);

        // 3: overflow and drain
        TxReady = 1'b0;
        for (int i = 0; i < 5; i++) wr(A_TX, 32'h41 + i);
        rd("ovf_status", A_TX, 32'hA);
        check("ovf_head", {24'h0, TxData}, 32'h41);
        TxReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_byte", {24'h0, TxData}, 32'h41 + i);
            @(negedge clk);
        end
        TxReady = 1'b0;
        rd("drained_status", A_TX, 32'h9);
        wr(A_CLR, 32'h0);
        rd("clr_status", A_TX, 32'h1);

        // 4: push and pop together while full
        for (int i = 0; i < 4; i++) wr(A_TX, 32'h41 + i);
        rd("full_status", A_TX, 32'h2);
        @(negedge clk);
        Adr = A_TX; WriteData = 32'h55; MemWrite = 1'b1; TxReady = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0; TxReady = 1'b0;
        rd("pushpop_status", A_TX, 32'h2);
        TxReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("pushpop_byte", {24'h0, TxData}, (i == 3) ? 32'h55 : 32'h42 + i);
            @(negedge clk);
        end
        TxReady = 1'b0;
        rd("pushpop_empty", A_TX, 32'h1);

        // 5: timer match and clear
        wr(A_TIMER, 32'h0);
        wr(A_CMP, 32'd20);
        wr(A_TIMER, 32'd10);   // edge k
        rd("timer_load", A_TIMER, 32'd10);
        for (int j = 0; j <= 10; j++) begin
            #1;
            check("irq_early", {31'h0, TimerIrq}, 32'h0);
            @(negedge clk);
        end
        #1;
        check("irq_match", {31'h0, TimerIrq}, 32'h1);
        rd("irq_status", A_TX, 32'h5);
        wr(A_CMP, 32'd20);
        #1;
        check("irq_cleared", {31'h0, TimerIrq}, 32'h0);
        rd("cmp_rd", A_CMP, 32'd20);

        // 6: reset with live state
        for (int i = 0; i < 3; i++) wr(A_TX, 32'h61 + i);
        wr(A_LED, 32'hA5);
        check("led_set", {24'h0, LED}, 32'hA5);
        rd("led_rd", A_LED, 32'hA5);
        check("fifo_3", {31'h0, TxValid}, 32'h1);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        #1;
        check("r6_txvalid", {31'h0, TxValid}, 32'h0);
        check("r6_txdata", {24'h0, TxData}, 32'h0);
        check("r6_led", {24'h0, LED}, 32'h0);
        rd("r6_status", A_TX, 32'h1);
        rd("r6_cmp", A_CMP, 32'hFFFF_FFFF);
        rd("r6_timer", A_TIMER, 32'h0);
        rd("r6_ram", 32'h10, 32'hDEAD_BEEF);
        rd("unmapped_rd", 32'h8000_0020, 32'h0);
        rd("clr_rd", A_CLR, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
